// File: rtl/mul_repeated_add.sv
// Unsigned WIDTH-bit multiplier by repeated addition: P = A added B times.
// Optional sticky overflow flag enabled by defining MUL_OVF_FLAG_EN.
module mul_repeated_add #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StAdd,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic             b_zero;

    // Ripple chain of full-adder cells computing P + A with cin = 0.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i] = p_q[i] ^ a_q[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (p_q[i] & a_q[i]) | (p_q[i] & carry[i]) | (a_q[i] & carry[i]);
        end
    end

    assign b_zero = (b_q == '0);

`ifdef MUL_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    logic cout;

    assign cout = (p_q[WIDTH-1] & a_q[WIDTH-1]) | (p_q[WIDTH-1] & carry[WIDTH-1]) |
                  (a_q[WIDTH-1] & carry[WIDTH-1]);
    assign ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StLoadB) begin
            ovf_d = 1'b0;
        end else if (state_q == StAdd && !b_zero) begin
            ovf_d = ovf_q | cout;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                a_d     = data_in;
                state_d = StLoadB;
            end
            StLoadB: begin
                b_d     = data_in;
                p_d     = '0;
                state_d = StAdd;
            end
            StAdd: begin
                if (b_zero) begin
                    state_d = StDone;
                end else begin
                    p_d = sum;
                    // Decrement kept off the shared adder.
                    b_d = b_q - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign product = p_q;
    assign done    = (state_q == StDone);
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mul_repeated_add.sv
// Scoreboard bench for mul_repeated_add: stimulus pushes expectations, a negedge
// monitor pops and checks product, latency and (if enabled) overflow on each done pulse.
module tb_mul_repeated_add;

    localparam int unsigned WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] p;
        logic             ovf;
        int               lat;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] product;
    logic             done;
    logic             busy;
`ifdef MUL_OVF_FLAG_EN
    logic             ovf;
`endif

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;
    int   busy_run;
    logic done_prev;

    mul_repeated_add #(
        .WIDTH(WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data_in(data_in),
        .product(product),
        .done   (done),
        .busy   (busy)
`ifdef MUL_OVF_FLAG_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: busy cycles preceding done must equal B+3 (LOADA, LOADB, B+1 ADD cycles).
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run  = 0;
            done_prev = 1'b0;
        end else begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("product", 32'(product), 32'(e.p));
                    check("latency", 32'(busy_run), 32'(e.lat));
                    check("busy_in_done", 32'(busy), 32'd1);
`ifdef MUL_OVF_FLAG_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
                if (done_prev) check("done_one_cycle", 32'd1, 32'd0);
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
            done_prev = done;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic hold, input logic pulse_start,
                          input logic [WIDTH-1:0] exp_p, input logic exp_ovf);
        exp_t e;
        int   k;
        @(negedge clk);
        check("idle_before_op", 32'(busy), 32'd0);
        start   = 1'b1;
        data_in = 16'h1234;
        e.p     = exp_p;
        e.ovf   = exp_ovf;
        e.lat   = int'(b) + 3;
        sb_q.push_back(e);
        @(negedge clk);
        data_in = a;
        start   = hold;
        @(negedge clk);
        data_in = b;
        @(negedge clk);
        data_in = 16'hBEEF;
        if (pulse_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        busy_run  = 0;
        done_prev = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        data_in   = '0;
        repeat (2) @(negedge clk);
        check("rst_product", 32'(product), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef MUL_OVF_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;

        run_op(16'd17, 16'd5, 1'b0, 1'b0, 16'd85, 1'b0);
        run_op(16'd17, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0);
        run_op(16'd0, 16'd5, 1'b0, 1'b0, 16'd0, 1'b0);
        run_op(16'd300, 16'd300, 1'b0, 1'b0, 16'd24464, 1'b1);
        run_op(16'd3, 16'd4, 1'b0, 1'b0, 16'd12, 1'b0);
        run_op(16'd17, 16'd5, 1'b0, 1'b1, 16'd85, 1'b0);

        // Product must hold through IDLE.
        repeat (3) @(negedge clk);
        check("product_hold_idle", 32'(product), 32'd85);

        // Abort mid-ADD: reset clears everything immediately.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        data_in = 16'd17;
        start   = 1'b0;
        @(negedge clk);
        data_in = 16'd5;
        repeat (3) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_product", 32'(product), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back with start held high.
        run_op(16'd6, 16'd7, 1'b1, 1'b0, 16'd42, 1'b0);
        run_op(16'd2, 16'd9, 1'b1, 1'b0, 16'd18, 1'b0);
        start = 1'b0;

        repeat (5) @(negedge clk);
        check("no_restart", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
